// File: rtl/booth_datapath_if.sv
// Bundle between the Booth sequencer and the multiplier datapath.
// The sequencer drives the round flags and operands; the datapath returns result/status.
interface booth_datapath_if #(
  parameter int size = 8
);
  logic              data_path_en;
  logic              first_round;
  logic              last_round;
  logic [size-1:0]   multiplicand;
  logic [size-1:0]   multiplier;
  logic [2*size-1:0] product;
  logic              done;
  logic              busy;

  modport master (
    output data_path_en, first_round, last_round,
    output multiplicand, multiplier,
    input  product, done, busy
  );

  modport slave (
    input  data_path_en, first_round, last_round,
    input  multiplicand, multiplier,
    output product, done, busy
  );
endinterface

// File: rtl/booth_datapath.sv
// Radix-2 signed Booth multiplier datapath.
// One load round, then one add/sub-and-shift per enabled round.
module booth_datapath #(
  parameter int size = 8
) (
  input logic             clk,
  input logic             rst,
  booth_datapath_if.slave bus
);
  localparam int W = size + 1;

  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      m_q, m_d;
  logic [size-1:0]   q_q, q_d;
  logic              qm1_q, qm1_d;
  logic [2*size-1:0] prod_q, prod_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [W-1:0]      sum;
  logic [2*size+1:0] shf;

  // Extra accumulator bit keeps A - M exact for M = -2^(size-1).
  always_comb begin
    sum = a_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
    shf = {sum[W-1], sum, q_q};
  end

  always_comb begin
    a_d    = a_q;
    m_d    = m_q;
    q_d    = q_q;
    qm1_d  = qm1_q;
    prod_d = prod_q;
    busy_d = busy_q;
    done_d = 1'b0;
    unique case (1'b1)
      !bus.data_path_en: begin
      end
      bus.data_path_en && bus.first_round: begin
        a_d    = '0;
        q_d    = bus.multiplier;
        qm1_d  = 1'b0;
        m_d    = {bus.multiplicand[size-1],
                  bus.multiplicand};
        busy_d = 1'b1;
      end
      bus.data_path_en && !bus.first_round: begin
        a_d   = shf[2*size+1:size+1];
        q_d   = shf[size:1];
        qm1_d = shf[0];
        if (bus.last_round) begin
          prod_d = shf[2*size:1];
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      m_q    <= '0;
      q_q    <= '0;
      qm1_q  <= 1'b0;
      prod_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      m_q    <= m_d;
      q_q    <= q_d;
      qm1_q  <= qm1_d;
      prod_q <= prod_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign bus.product = prod_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_booth_datapath.sv
// Self-checking bench for booth_datapath (size=8).
// Directed table, corner sequences, and random ops against signed multiply.
module tb_booth_datapath;
  localparam int SZ = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_datapath_if #(.size(SZ)) bus ();

  booth_datapath #(.size(SZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string             name;
    logic signed [7:0] m;
    logic signed [7:0] q;
    logic [15:0]       exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc(bit en, bit f, bit l);
    @(negedge clk);
    bus.data_path_en = en;
    bus.first_round  = f;
    bus.last_round   = l;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_mul(logic signed [7:0] m,
                                          logic signed [7:0] q);
    int p;
    p = int'(m) * int'(q);
    return p[15:0];
  endfunction

  // One full operation; optional stall before step stall_at+1 and
  // optional operand scrambling while busy.
  task automatic run_op(string name, logic [7:0] m, logic [7:0] q,
                        logic [15:0] exp, int stall_at, int stall_len,
                        bit scramble);
    int early;
    int busy_bad;
    early    = 0;
    busy_bad = 0;
    bus.multiplicand = m;
    bus.multiplier   = q;
    cyc(1, 1, 0);
    chk({name, "_busy_load"}, 32'(bus.busy), 32'd1);
    chk({name, "_done_load"}, 32'(bus.done), 32'd0);
    for (int i = 1; i <= SZ; i++) begin
      if (i - 1 == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          cyc(0, 0, 0);
          if (bus.busy !== 1'b1) busy_bad++;
          if (bus.done !== 1'b0) early++;
        end
      end
      if (scramble) begin
        bus.multiplicand = 8'($urandom);
        bus.multiplier   = 8'($urandom);
      end
      cyc(1, 0, i == SZ);
      if (i < SZ && bus.done !== 1'b0) early++;
      if (i < SZ && bus.busy !== 1'b1) busy_bad++;
    end
    chk({name, "_early_done"}, 32'(early), 32'd0);
    chk({name, "_busy_during"}, 32'(busy_bad), 32'd0);
    chk({name, "_done"}, 32'(bus.done), 32'd1);
    chk({name, "_product"}, 32'(bus.product), 32'(exp));
    chk({name, "_busy_end"}, 32'(bus.busy), 32'd0);
    cyc(0, 0, 0);
    chk({name, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({name, "_hold"}, 32'(bus.product), 32'(exp));
  endtask

  initial begin
    int dones;
    int bad_hold;
    logic [7:0] rm, rq;

    vecs[0] = '{"p3x5",     8'sd3,    8'sd5,   16'h000F};
    vecs[1] = '{"m3x5",    -8'sd3,    8'sd5,   16'hFFF1};
    vecs[2] = '{"m128xm128", -8'sd128, -8'sd128, 16'h4000};
    vecs[3] = '{"m128x127", -8'sd128,  8'sd127, 16'hC080};
    vecs[4] = '{"0xm1",     8'sd0,   -8'sd1,   16'h0000};

    rst = 1'b0;
    bus.data_path_en = 1'b0;
    bus.first_round  = 1'b0;
    bus.last_round   = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_product", 32'(bus.product), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    @(negedge clk);
    rst = 1'b1;

    // Step with last_round straight out of reset: all-zero state
    cyc(1, 0, 1);
    chk("noload_done", 32'(bus.done), 32'd1);
    chk("noload_product", 32'(bus.product), 32'd0);
    chk("noload_busy", 32'(bus.busy), 32'd0);

    foreach (vecs[k])
      run_op(vecs[k].name, vecs[k].m, vecs[k].q, vecs[k].exp, -1, 0, 0);

    run_op("stall", 8'd3, 8'd5, 16'h000F, 3, 4, 0);

    // Reload mid-operation after step 5
    bus.multiplicand = 8'd2;
    bus.multiplier   = 8'd2;
    cyc(1, 1, 0);
    dones    = 0;
    bad_hold = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0);
      if (bus.done) dones++;
      if (bus.product !== 16'h000F) bad_hold++;
    end
    bus.multiplicand = 8'd7;
    bus.multiplier   = 8'hFE;
    cyc(1, 1, 0);
    if (bus.product !== 16'h000F) bad_hold++;
    for (int i = 1; i <= SZ; i++) begin
      cyc(1, 0, i == SZ);
      if (bus.done) dones++;
      if (i < SZ && bus.product !== 16'h000F) bad_hold++;
    end
    chk("reload_product", 32'(bus.product), 32'h0000FFF2);
    chk("reload_hold", 32'(bad_hold), 32'd0);
    cyc(0, 0, 0);
    chk("reload_dones", 32'(dones), 32'd1);

    // first_round wins over last_round
    bus.multiplicand = 8'd3;
    bus.multiplier   = 8'd5;
    cyc(1, 1, 1);
    chk("fl_busy", 32'(bus.busy), 32'd1);
    chk("fl_done", 32'(bus.done), 32'd0);
    chk("fl_prod", 32'(bus.product), 32'h0000FFF2);
    for (int i = 1; i <= SZ; i++) cyc(1, 0, i == SZ);
    chk("fl_result", 32'(bus.product), 32'h0000000F);

    // Asynchronous reset during step 4
    bus.multiplicand = 8'd6;
    bus.multiplier   = 8'd6;
    cyc(1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    @(negedge clk);
    bus.data_path_en = 1'b1;
    bus.first_round  = 1'b0;
    bus.last_round   = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_product", 32'(bus.product), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.data_path_en = 1'b0;
    run_op("after_rst", 8'd6, 8'd6, 16'h0024, -1, 0, 0);

    // Random ops with random stalls and operand churn while busy
    for (int n = 0; n < 150; n++) begin
      rm = 8'($urandom);
      rq = 8'($urandom);
      run_op("rand", rm, rq, ref_mul(rm, rq),
             int'($urandom_range(0, 9)) - 1,
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
